// File: rtl/pipelined_adder_tree_if.sv
// Operand-vector / sum handshake bundle for pipelined_adder_tree.
interface pipelined_adder_tree_if #(
  parameter int WIDTH     = 32,
  parameter int INPUT_NUM = 8
);
  logic [INPUT_NUM-1:0][WIDTH-1:0] in;
  logic                            in_valid;
  logic                            in_ready;
  logic [WIDTH-1:0]                out;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_sat;

  modport master (output in, in_valid, out_ready,
                  input  in_ready, out, out_valid, out_sat);
  modport slave  (input  in, in_valid, out_ready,
                  output in_ready, out, out_valid, out_sat);
endinterface

// File: rtl/pipelined_adder_tree.sv
// Pipelined INPUT_NUM-operand adder tree, one register per level, global advance enable.
// Define ADDER_TREE_SAT_EN for signed width-growing levels and a saturating output.

module pat_node #(
  parameter int IW = 32,
  parameter int OW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [IW-1:0] a_i,
  input  logic [IW-1:0] b_i,
  output logic [OW-1:0] s_o
);
  logic [OW-1:0] s_q, s_d;

  // OW exceeds IW only when levels grow; the cast then sign-extends.
  assign s_d = OW'($signed(a_i)) + OW'($signed(b_i));
  assign s_o = s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   s_q <= '0;
    else if (en_i) s_q <= s_d;
  end
endmodule

module pipelined_adder_tree #(
  parameter int WIDTH     = 32,
  parameter int INPUT_NUM = 8
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  pipelined_adder_tree_if.slave tif
);
  localparam int LEVELS = $clog2(INPUT_NUM);
`ifdef ADDER_TREE_SAT_EN
  localparam int GROW = 1;
`else
  localparam int GROW = 0;
`endif

  function automatic int cnt(input int k);
    int c;
    c = INPUT_NUM;
    for (int j = 0; j < k; j++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int lw(input int k);
    return WIDTH + GROW * k;
  endfunction

  // Bit offset of level k inside the flattened node vector.
  function automatic int base(input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += cnt(j) * lw(j);
    return o;
  endfunction

  localparam int TREE_W = base(LEVELS);
  localparam int LB     = base(LEVELS - 1);
  localparam int LW     = lw(LEVELS - 1);
  localparam int FW     = lw(LEVELS);

  logic              adv;
  logic [LEVELS:1]   vld_pipe;
  logic [TREE_W-1:0] tree;
  logic [FW-1:0]     fsum;
  logic [WIDTH-1:0]  out_q, out_d;

  assign adv           = !vld_pipe[LEVELS] || tif.out_ready;
  assign tif.in_ready  = adv;
  assign tif.out_valid = vld_pipe[LEVELS];
  assign tif.out       = out_q;
  assign tree[INPUT_NUM*WIDTH-1:0] = tif.in;

  for (genvar k = 1; k < LEVELS; k++) begin : g_lvl
    for (genvar i = 0; i < cnt(k); i++) begin : g_node
      if (2*i + 1 < cnt(k-1)) begin : g_pair
        pat_node #(.IW(lw(k-1)), .OW(lw(k))) u_node (
          .clk_i, .rst_ni, .en_i(adv),
          .a_i(tree[base(k-1) + 2*i*lw(k-1)     +: lw(k-1)]),
          .b_i(tree[base(k-1) + (2*i+1)*lw(k-1) +: lw(k-1)]),
          .s_o(tree[base(k) + i*lw(k) +: lw(k)])
        );
      end else begin : g_pass
        // Odd node out: registered unchanged so every path has equal depth.
        pat_node #(.IW(lw(k-1)), .OW(lw(k))) u_node (
          .clk_i, .rst_ni, .en_i(adv),
          .a_i(tree[base(k-1) + 2*i*lw(k-1) +: lw(k-1)]),
          .b_i('0),
          .s_o(tree[base(k) + i*lw(k) +: lw(k)])
        );
      end
    end
  end

  // The level before the output always holds exactly two nodes.
  assign fsum = FW'($signed(tree[LB +: LW])) + FW'($signed(tree[LB + LW +: LW]));

`ifdef ADDER_TREE_SAT_EN
  localparam logic [FW-1:0] SMAX = {{(FW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [FW-1:0] SMIN = ~SMAX;
  logic sat_q, sat_d;

  always_comb begin
    out_d = fsum[WIDTH-1:0];
    sat_d = 1'b0;
    if ($signed(fsum) > $signed(SMAX)) begin
      out_d = SMAX[WIDTH-1:0];
      sat_d = 1'b1;
    end else if ($signed(fsum) < $signed(SMIN)) begin
      out_d = SMIN[WIDTH-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  sat_q <= 1'b0;
    else if (adv) sat_q <= sat_d;
  end

  assign tif.out_sat = sat_q;
`else
  assign out_d       = fsum;
  assign tif.out_sat = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      out_q    <= '0;
    end else if (adv) begin
      vld_pipe[1] <= tif.in_valid;
      for (int s = 2; s <= LEVELS; s++) vld_pipe[s] <= vld_pipe[s-1];
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench: a main tree and a 5-input tree driven with shared handshakes.
module tb_pipelined_adder_tree;
`ifdef ADDER_TREE_SAT_EN
  localparam int W = 8;
  localparam int N = 4;
`else
  localparam int W = 32;
  localparam int N = 8;
`endif
  localparam int N5 = 5;
  localparam int L0 = $clog2(N);
  localparam int L1 = $clog2(N5);

  typedef logic [W-1:0] op_t;
  typedef struct {
    op_t  sum;
    logic sat;
    int   t;
    bit   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   lat_mode = 1'b1;
  bit   do_final = 1'b0;
  bit   final_done = 1'b0;
  int   acc_cnt = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic hold  [2];
  op_t  hold_o[2];
  logic hold_s[2];

  pipelined_adder_tree_if #(.WIDTH(W), .INPUT_NUM(N))  ifm ();
  pipelined_adder_tree_if #(.WIDTH(W), .INPUT_NUM(N5)) if5 ();

  pipelined_adder_tree #(.WIDTH(W), .INPUT_NUM(N)) dut_main (
    .clk_i(clk), .rst_ni(rst_n), .tif(ifm));
  pipelined_adder_tree #(.WIDTH(W), .INPUT_NUM(N5)) dut_five (
    .clk_i(clk), .rst_ni(rst_n), .tif(if5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer sum of all operands, wrapped or clamped.
  function automatic void ref_sum(input op_t ops[$], output op_t r, output logic s);
    longint acc;
    acc = 0;
    s   = 1'b0;
`ifdef ADDER_TREE_SAT_EN
    foreach (ops[i]) acc += longint'($signed(ops[i]));
    if (acc > (longint'(1) << (W-1)) - 1) begin
      r = op_t'((longint'(1) << (W-1)) - 1);
      s = 1'b1;
    end else if (acc < -(longint'(1) << (W-1))) begin
      r = op_t'(-(longint'(1) << (W-1)));
      s = 1'b1;
    end else begin
      r = op_t'(acc);
    end
`else
    foreach (ops[i]) acc += longint'(ops[i]);
    r = op_t'(acc);
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic iv, input logic ir, input logic ov,
                     input logic ordy, input op_t o, input logic s, input int lv,
                     input op_t ops[$]);
    exp_t e;
    bit   got;
    chk($sformatf("in_ready%0d", d), ir, !ov || ordy);
    if (hold[d]) begin
      chk($sformatf("hold_out%0d", d), o, hold_o[d]);
      chk($sformatf("hold_sat%0d", d), s, hold_s[d]);
      chk($sformatf("hold_vld%0d", d), ov, 1);
    end
    hold[d]   = ov && !ordy;
    hold_o[d] = o;
    hold_s[d] = s;
    if (ov && ordy) begin
      got = 1'b0;
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL out%0d_unexpected: got %0h with nothing outstanding", d, o);
      end else begin
        chk($sformatf("sum%0d", d), o, e.sum);
        chk($sformatf("sat%0d", d), s, e.sat);
        if (e.lat) chk($sformatf("latency%0d", d), cyc - e.t, lv);
      end
    end
    if (iv && ir) begin
      ref_sum(ops, e.sum, e.sat);
      e.t   = cyc;
      e.lat = lat_mode;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    op_t ops0[$];
    op_t ops1[$];
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_out", ifm.out, 0);
        chk("rst_vld", ifm.out_valid, 0);
        chk("rst_sat", ifm.out_sat, 0);
        chk("rst_vld5", if5.out_valid, 0);
        q0.delete();
        q1.delete();
        hold[0] = 1'b0;
        hold[1] = 1'b0;
      end else begin
        ops0.delete();
        ops1.delete();
        for (int i = 0; i < N;  i++) ops0.push_back(ifm.in[i]);
        for (int i = 0; i < N5; i++) ops1.push_back(if5.in[i]);
        mon(0, ifm.in_valid, ifm.in_ready, ifm.out_valid, ifm.out_ready,
            ifm.out, ifm.out_sat, L0, ops0);
        mon(1, if5.in_valid, if5.in_ready, if5.out_valid, if5.out_ready,
            if5.out, if5.out_sat, L1, ops1);
        if (do_final && !final_done) begin
          chk("drain_main", q0.size(), 0);
          chk("drain_five", q1.size(), 0);
          chk("stream_accepted", acc_cnt, 100);
          final_done = 1'b1;
        end
      end
    end
  end

  function automatic op_t pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return op_t'(1) << (W-1);
      3:       return ~(op_t'(1) << (W-1));
      default: return op_t'($urandom);
    endcase
  endfunction

  task automatic rand_vec();
    for (int i = 0; i < N;  i++) ifm.in[i] = pick();
    for (int i = 0; i < N5; i++) if5.in[i] = pick();
  endtask

  task automatic set_hs(input logic v, input logic r);
    ifm.in_valid  = v;
    if5.in_valid  = v;
    ifm.out_ready = r;
    if5.out_ready = r;
  endtask

  task automatic put4(input int a, input int b, input int c, input int e);
    ifm.in[0] = op_t'(a);
    ifm.in[1] = op_t'(b);
    ifm.in[2] = op_t'(c);
    ifm.in[3] = op_t'(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nrm;
    rst_n = 1'b0;
    set_hs(1'b1, 1'b1);
    rand_vec();
    repeat (4) begin step(); rand_vec(); end
    rst_n = 1'b1;
    repeat (2) begin step(); rand_vec(); end
    set_hs(1'b0, 1'b1);
    repeat (6) step();

    // Directed vectors, back to back.
`ifdef ADDER_TREE_SAT_EN
    put4(100, 100, 100, -20);
`else
    for (int i = 0; i < N; i++) ifm.in[i] = op_t'(i + 1);
`endif
    for (int i = 0; i < N5; i++) if5.in[i] = op_t'(10 * (i + 1));
    set_hs(1'b1, 1'b1);
    step();
`ifdef ADDER_TREE_SAT_EN
    put4(-128, -128, 0, 0);
`else
    for (int i = 0; i < N; i++) ifm.in[i] = '1;
`endif
    for (int i = 0; i < N5; i++) if5.in[i] = '1;
    step();
`ifdef ADDER_TREE_SAT_EN
    put4(50, -20, 10, 5);
    for (int i = 0; i < N5; i++) if5.in[i] = pick();
    step();
`endif
    set_hs(1'b0, 1'b1);
    repeat (6) step();

    // Random streaming with backpressure.
    lat_mode = 1'b0;
    for (int c = 0; c < 3000 && acc_cnt < 100; c++) begin
      rand_vec();
      set_hs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      #1;
      if (ifm.in_valid && ifm.in_ready) acc_cnt++;
      step();
    end
    set_hs(1'b0, 1'b1);
    repeat (10) step();

    // Reset with vectors in flight.
    lat_mode = 1'b1;
    nrm = (L0 < 3) ? L0 : 3;
    set_hs(1'b1, 1'b1);
    repeat (nrm) begin rand_vec(); step(); end
    rst_n = 1'b0;
    set_hs(1'b0, 1'b1);
    repeat (2) step();
    rst_n = 1'b1;
    rand_vec();
    set_hs(1'b1, 1'b1);
    step();
    set_hs(1'b0, 1'b1);
    repeat (6) step();

    do_final = 1'b1;
    for (int c = 0; c < 10 && !final_done; c++) step();
    if (!final_done) begin
      errors++;
      checks++;
      $display("FAIL final_check: monitor did not complete final checks");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
Parametrised, pipelined successor to the 4-input combinational adder tree. Reduces INPUT_NUM operands of WIDTH bits to one sum through ceil(log2(INPUT_NUM)) registered adder levels, with valid/ready handshakes on both sides. Sits between the multiplier array and the accumulator in the convolution datapath, summing partial products of one kernel window per transfer.

Parameters:
WIDTH, 32, operand and result width in bits (two's complement when saturation is enabled).
INPUT_NUM, 8, number of operands; must be >= 2; any value is legal, power of two not required.
LEVELS, $clog2(INPUT_NUM), localparam: number of tree levels and pipeline stages.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset (asserted at 0).
in  input  [INPUT_NUM-1:0][WIDTH-1:0]  operand vector; in[0] is the lowest operand.
in_valid  input  1  operand vector valid.
in_ready  output  1  tree can accept a vector this cycle.
out  output  [WIDTH-1:0]  sum result.
out_valid  output  1  out holds a valid result.
out_ready  input  1  downstream accepts out this cycle.
out_sat  output  1  result was clamped; tied 0 when saturation is compiled out.

Behaviour:
- Reset (rst=0, asynchronous): all stage data registers 0, all stage valid bits 0; out=0, out_valid=0, out_sat=0. Any in-flight vectors are discarded.
- Tree structure: level k pairs adjacent nodes of level k-1, giving node i = node 2i + node 2i+1.
- Odd node count at a level: the last node passes through unchanged and is registered like the others.
- The result is registered after every level. Stage LEVELS is the output register.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid and out_ready only.
- When adv=1, every stage loads from the stage before it, including its valid bit. Stage 1 loads from in and in_valid. Input transfer occurs when in_valid && in_ready.
- When adv=0, all stages hold data and valid. Stalls do not collapse bubbles.
- Latency: a vector accepted in cycle t appears with out_valid=1 in cycle t+LEVELS if adv stays 1. Each stall cycle adds one cycle.
- Throughput: one vector per cycle when out_ready is held at 1.
- Ordering: results leave in acceptance order. No vector is dropped or duplicated.
- out and out_sat are stable while out_valid=1 and out_ready=0.
- Arithmetic without the optional feature: unsigned/two's-complement sum, every node WIDTH bits, result wraps modulo 2^WIDTH.
- Invalid stages still propagate data, but that data is don't-care. out is only meaningful when out_valid=1.
- INPUT_NUM=2 gives LEVELS=1: a single registered adder.
- rst asserted mid-stream: the pipeline empties immediately. The first post-reset result is the first vector accepted after rst returns to 1.

Optional Feature:
Macro ADDER_TREE_SAT_EN.
- Defined: operands are signed. Level k nodes are WIDTH+k bits and sign-extended, so no intermediate overflow. The final stage clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. out_sat=1 exactly when clamping occurred, registered alongside out.
- Not defined: wrap-around arithmetic as above, out_sat constant 0, no extended-width registers.

Test Plan:
- Reset/idle: rst=0 with random in and in_valid=1, then release -> out=0, out_valid=0, out_sat=0 during reset; first out_valid exactly LEVELS cycles after the first accepted vector.
- Basic sum, INPUT_NUM=8, WIDTH=32: in={1..8}, in_valid=1 for one cycle, out_ready=1 -> out=36 with out_valid=1 for one cycle, 3 cycles after acceptance.
- Streaming with backpressure: 100 random vectors with random in_valid and random out_ready -> output sequence equals the scoreboard modulo 2^32 in order; out held stable while stalled; in_ready==(!out_valid||out_ready) every cycle.
- Non-power-of-two, INPUT_NUM=5: in={10,20,30,40,50} -> out=150 after 3 cycles. Wrap case in={all 32'hFFFFFFFF} -> out=32'hFFFFFFFB, out_sat=0 (macro off).
- Saturation, ADDER_TREE_SAT_EN, WIDTH=8, INPUT_NUM=4: in={100,100,100,-20} -> out=127, out_sat=1. in={-128,-128,0,0} -> out=-128, out_sat=1. in={50,-20,10,5} -> out=45, out_sat=0.
- Reset mid-operation: accept 3 vectors, assert rst=0 before any emerge, release -> none of the 3 ever appears at the output; the next vector emerges LEVELS cycles after acceptance.
